mod_dp: RTL

Datapath for the repeated-subtraction modulo/divide unit. It executes the save, subtract and compare commands issued by `mod_cu` and returns the `temp_less_than` status that moves the controller from its subtract/compare state to its save state. It holds the operands, the running remainder and the quotient, and publishes a registered result with a `done` flag. `mod_cu` and `mod_dp` are instantiated side by side inside the ALU's modulo path.

---
 rtl/mod_pkg.sv | 13 +
 rtl/mod_sub_cmp.sv | 32 +++
 rtl/mod_dp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared types for the modulo/divide unit.
// Command bundle is common to mod_cu and mod_dp.
package mod_pkg;

  localparam int MOD_WIDTH = 32;

  typedef struct packed {
    logic save;
    logic substract;
    logic compare;
  } mod_cmd_t;

endpackage

// File: rtl/mod_sub_cmp.sv
// Guarded subtract and compare for the modulo datapath.
// Pure combinational; mod_dp registers the outputs.
module mod_sub_cmp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH-1:0] temp_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             sub_en_i,
  output logic [WIDTH-1:0] temp_next_o,
  output logic             do_sub_o,
  output logic             ge_o,
  output logic             lt_next_o,
  output logic             div_zero_o
);

  assign ge_o       = (temp_i >= divisor_i);
  assign div_zero_o = (divisor_i == '0);
  assign do_sub_o   = sub_en_i & ge_o & ~div_zero_o;

  // Subtract only when it cannot underflow; extra cycles are no-ops.
  always_comb begin
    temp_next_o = temp_i;
    if (do_sub_o) begin
      temp_next_o = temp_i - divisor_i;
    end
  end

  assign lt_next_o = div_zero_o | (temp_next_o < divisor_i);

endmodule

// File: rtl/mod_dp.sv
// Datapath for the repeated-subtraction modulo/divide unit.
// Holds operands, remainder, quotient and the status flags.
module mod_dp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             save_command,
  input  logic             substract_command,
  input  logic             compare_command,
  output logic             temp_less_than,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             div_by_zero
);

  mod_cmd_t cmd;

  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             lt_q, lt_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] temp_next;
  logic             do_sub;
  logic             ge;
  logic             lt_next;
  logic             div_zero;

  assign cmd = '{
    save:      save_command,
    substract: substract_command,
    compare:   compare_command
  };

  mod_sub_cmp #(
    .WIDTH(WIDTH)
  ) u_sub_cmp (
    .temp_i     (temp_q),
    .divisor_i  (div_q),
    .sub_en_i   (cmd.substract),
    .temp_next_o(temp_next),
    .do_sub_o   (do_sub),
    .ge_o       (ge),
    .lt_next_o  (lt_next),
    .div_zero_o (div_zero)
  );

  // Next state: load beats save, save beats subtract/compare.
  always_comb begin
    temp_d = temp_q;
    div_d  = div_q;
    quot_d = quot_q;
    res_d  = res_q;
    lt_d   = lt_q;
    done_d = done_q;
    dbz_d  = dbz_q;
    if (load) begin
      temp_d = a_in;
      div_d  = b_in;
      quot_d = '0;
      lt_d   = 1'b0;
      done_d = 1'b0;
      dbz_d  = 1'b0;
    end else if (cmd.save) begin
      res_d  = temp_q;
      done_d = 1'b1;
    end else begin
      if (do_sub) begin
        temp_d = temp_next;
        quot_d = quot_q + WIDTH'(1);
      end
      if (cmd.compare) begin
        lt_d = lt_next;
        if (div_zero) begin
          dbz_d = 1'b1;
        end
      end
    end
  end

  // State registers; async reset wipes any partial result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp_q <= '0;
      div_q  <= '0;
      quot_q <= '0;
      res_q  <= '0;
      lt_q   <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      temp_q <= temp_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      res_q  <= res_d;
      lt_q   <= lt_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  assign temp_less_than = lt_q;
  assign result         = res_q;
  assign quotient       = quot_q;
  assign done           = done_q;
  assign div_by_zero    = dbz_q;

  logic unused_ge;
  assign unused_ge = ge;

endmodule
